// File: rtl/UARTTypes.sv
// Shared 8N1 framing constants and receiver state encodings.
package UARTTypes;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
    localparam int unsigned STATE_W   = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_START = 3'd1;
    localparam logic [STATE_W-1:0] S_DATA  = 3'd2;
    localparam logic [STATE_W-1:0] S_STOP  = 3'd3;
    localparam logic [STATE_W-1:0] S_BREAK = 3'd4;

endpackage

// File: rtl/Synchronizer.sv
// Two-flop synchronizer for asynchronous inputs, parameterized width and reset value.
module Synchronizer #(
    parameter int unsigned WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ascii_uart_rx.sv
// 8N1 UART receiver feeding the character display's ascii/ascii_val inputs.
module ascii_uart_rx
    import UARTTypes::*;
#(
    parameter int unsigned p_clks_per_bit = 217
) (
    input  logic       clk_25M,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] ascii,
    output logic       ascii_val,
    output logic       frame_err
);

    localparam int unsigned CW = $clog2(p_clks_per_bit);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(p_clks_per_bit - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(p_clks_per_bit / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    logic [STATE_W-1:0]   state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bit_idx, bit_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [7:0]           ascii_nxt;
    logic                 val_nxt, ferr_nxt;

    Synchronizer #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk_25M),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk_25M) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            ascii     <= 8'h00;
            ascii_val <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_nxt;
            shift     <= shift_nxt;
            ascii     <= ascii_nxt;
            ascii_val <= val_nxt;
            frame_err <= ferr_nxt;
        end
    end

    // Start bit is re-checked at mid-bit; every later sample lands one full bit period on.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        ascii_nxt = ascii;
        val_nxt   = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (!rx_s) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cnt == CNT_MID) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_s;
                    if (bit_idx == BIT_LAST) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        ascii_nxt = shift;
                        val_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/ascii_uart_rx.md
ASCII_UART_RX -- requirements
Module: ascii_uart_rx

Interface
REQ-001 The block SHALL have parameter p_clks_per_bit, default 217, meaning clk_25M cycles per UART bit (115200 baud at 25 MHz); legal values are 4 or greater.
REQ-002 The block SHALL have port clk_25M  input  1  the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port rx  input  1  asynchronous UART serial line, 8N1 framing, LSB first, idle high.
REQ-005 The block SHALL have port ascii  output  8  last correctly received byte, driven to the ascii input of the character display.
REQ-006 The block SHALL have port ascii_val  output  1  one-cycle pulse marking a new valid byte on ascii; there is no ready or backpressure.
REQ-007 The block SHALL have port frame_err  output  1  one-cycle pulse on a stop-bit violation.

Function
REQ-008 The block SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-009 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK.
REQ-010 In IDLE, rx_s==0 SHALL move the FSM to START with the bit counter cleared.
REQ-011 In START, the block SHALL sample rx_s at counter==p_clks_per_bit/2-1 (integer division); 0 moves to DATA with counter cleared; 1 is a glitch and returns to IDLE with no output.
REQ-012 In DATA, the block SHALL sample rx_s every p_clks_per_bit cycles into shift bit 0..7, LSB first; after the 8th sample the FSM moves to STOP.
REQ-013 In STOP, the block SHALL sample rx_s after p_clks_per_bit cycles; 1 latches the shift register into ascii, pulses ascii_val the next cycle, and moves to IDLE.
REQ-014 In STOP, a 0 sample SHALL pulse frame_err the next cycle, leave ascii unchanged, produce no ascii_val, and move to BREAK.
REQ-015 BREAK SHALL wait for rx_s==1 and then move to IDLE.
REQ-016 ascii SHALL hold its value between valid bytes.
REQ-017 ascii_val and frame_err SHALL never be asserted in the same cycle, and each SHALL last exactly one cycle.
REQ-018 The counter SHALL be $clog2(p_clks_per_bit) bits wide, unsigned, and compared for equality only; it SHALL never wrap past p_clks_per_bit-1.
REQ-019 A back-to-back start bit immediately after a valid stop-bit sample SHALL be accepted; IDLE is entered in time to detect it.
REQ-020 Latency SHALL be 2 synchronizer cycles plus about 9.5 bit periods plus 1 cycle, measured from the rx falling edge to the ascii_val pulse.

Reset
REQ-021 On rst, the FSM SHALL go to IDLE, the counter, shift register and ascii SHALL be set to 0x00, ascii_val and frame_err to 0, and both synchronizer flops to 1.
REQ-022 An rst asserted mid-frame SHALL discard the partial byte with no pulse emitted.
REQ-023 If rx is low when rst deasserts, the block SHALL treat it as a start bit.

Structure
REQ-024 The state enum and the 8N1 constants (data bits = 8, stop bits = 1) SHALL live in a shared package UARTTypes.
REQ-025 The synchronizer SHALL be a separate sub-module Synchronizer, parameterized by width, reset value 1.
REQ-026 The block SHALL be instantiable directly in front of the character display's ascii and ascii_val inputs.

Verification
REQ-027 With p_clks_per_bit=8, sending 0x41 SHALL give ascii=0x41 and a single ascii_val pulse 79 +/-1 cycles after the rx falling edge, with frame_err staying 0.
REQ-028 With p_clks_per_bit=8, a 2-cycle low glitch on idle rx SHALL give no ascii_val and no frame_err, and the FSM SHALL return to IDLE.
REQ-029 With p_clks_per_bit=8, sending 0x55 with stop bit 0 SHALL give one frame_err pulse, no ascii_val, and ascii unchanged; a later 0x5A sent after rx returns high SHALL be received correctly.
REQ-030 With p_clks_per_bit=8, back-to-back 0x48 then 0x69 with no idle gap SHALL give two ascii_val pulses carrying 0x48 then 0x69.
REQ-031 With p_clks_per_bit=8, rst asserted during bit 4 of 0x33 SHALL give no pulse; a following 0x7E SHALL be received correctly.
REQ-032 With p_clks_per_bit=217, sending 0x0A SHALL give ascii_val with ascii=0x0A, and the 2-stage synchronizer latency SHALL be confirmed.
